// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_like_arbiter                                            |
// | Description : Shares one SRAM-like slave port between the instruction and  |
// |               data requesters, routing in-order responses via an ID FIFO.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sram_like_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [3:0]          inst_wstrb,
    input  logic [31:0]         inst_addr,
    input  logic [31:0]         inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [31:0]         inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [3:0]          data_wstrb,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [31:0]         data_rdata,

    output logic                sl_req,
    output logic                sl_wr,
    output logic [1:0]          sl_size,
    output logic [3:0]          sl_wstrb,
    output logic [31:0]         sl_addr,
    output logic [31:0]         sl_wdata,
    input  logic                sl_addr_ok,
    input  logic                sl_data_ok,
    input  logic [31:0]         sl_rdata,

    output logic [PTR_W:0]      outst_cnt,
    output logic                proto_err
);

    localparam logic           c_INST  = 1'b0;
    localparam logic           c_DATA  = 1'b1;
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(OUTST_DEPTH);
    localparam logic [PTR_W:0] c_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    logic                lock_valid_q, lock_valid_d;
    logic                lock_id_q,    lock_id_d;
    logic                id_fifo_q [OUTST_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      cnt_q,    cnt_d;
    logic                proto_err_q, proto_err_d;

    logic                w_grant;
    logic                w_gnt_req;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_pop;
    logic                w_head;

    // A locked grant takes precedence so an in-flight request is never swapped out.
    always_comb begin
        w_grant = c_DATA;
        if (lock_valid_q) begin
            w_grant = lock_id_q;
        end else if (data_req) begin
            w_grant = c_DATA;
        end else if (inst_req) begin
            w_grant = c_INST;
        end
    end

    assign w_gnt_req = (w_grant == c_DATA) ? data_req : inst_req;
    assign w_full    = (cnt_q == c_DEPTH);
    assign w_empty   = (cnt_q == '0);

    assign sl_req    = w_gnt_req & ~w_full;
    assign sl_wr     = (w_grant == c_DATA) ? data_wr    : inst_wr;
    assign sl_size   = (w_grant == c_DATA) ? data_size  : inst_size;
    assign sl_wstrb  = (w_grant == c_DATA) ? data_wstrb : inst_wstrb;
    assign sl_addr   = (w_grant == c_DATA) ? data_addr  : inst_addr;
    assign sl_wdata  = (w_grant == c_DATA) ? data_wdata : inst_wdata;

    assign w_accept  = sl_req & sl_addr_ok;
    assign w_pop     = sl_data_ok & ~w_empty;
    assign w_head    = id_fifo_q[rd_ptr_q];

    assign inst_addr_ok = w_accept & (w_grant == c_INST);
    assign data_addr_ok = w_accept & (w_grant == c_DATA);
    assign inst_data_ok = w_pop & (w_head == c_INST);
    assign data_data_ok = w_pop & (w_head == c_DATA);
    assign inst_rdata   = sl_rdata;
    assign data_rdata   = sl_rdata;

    assign outst_cnt = cnt_q;
    assign proto_err = proto_err_q;

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        proto_err_d  = proto_err_q | (sl_data_ok & w_empty);

        if (w_accept) begin
            lock_valid_d = 1'b0;
        end else if (sl_req) begin
            lock_valid_d = 1'b1;
            lock_id_d    = w_grant;
        end

        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end

        case ({w_accept, w_pop})
            2'b10:   cnt_d = cnt_q + c_ONE;
            2'b01:   cnt_d = cnt_q - c_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= c_INST;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            proto_err_q  <= 1'b0;
            for (int i = 0; i < OUTST_DEPTH; i++) begin
                id_fifo_q[i] <= c_INST;
            end
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            proto_err_q  <= proto_err_d;
            if (w_accept) begin
                id_fifo_q[wr_ptr_q] <= w_grant;
            end
        end
    end

endmodule
`default_nettype wire
